seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//  Receive-side counterpart of the 7-segment digit driver. Samples a multiplexed
//  active-low 7-seg bus (segments + digit anodes) and decodes each lit pattern
//  back to a 4-bit digit value per position. Qualifies each pattern over several
//  cycles and flags illegal patterns. Used for display loop-back checking and
//  for front-panel readback in the vending controller.
// PARAMETERS
//  NUM_DIGITS  4  number of anode lines / digit positions (1..8)
//  STABLE_CNT  3  consecutive identical synced samples required to commit (>=1)
// PORTS
//  clk          in   1             system clock, rising edge
//  rst_n        in   1             reset, asynchronous assert, active-low
//  seg_pins     in   8             active-low segments; [7]=dp, [6:0]=g..a
//  an_n         in   NUM_DIGITS    active-low digit enables; legal = one-hot-low
//  digit_out    out  4*NUM_DIGITS  decoded value, position i at [4i+3:4i]
//  dp_out       out  NUM_DIGITS    dp lit (seg_pins[7]==0) at last commit
//  digit_valid  out  NUM_DIGITS    position holds a legally decoded value
//  upd_stb      out  1             1-cycle pulse: a stored digit or dp changed
//  err_stb      out  1             1-cycle pulse: illegal pattern committed
//  err_idx      out  3             position of last error (held until next error)
// BEHAVIOUR
//  - Reset: digit_out=all 4'hF, dp_out=0, digit_valid=0, upd_stb=0, err_stb=0,
//    err_idx=0, sync regs=all 1s, state=IDLE, stable counter=0.
//  - seg_pins and an_n pass through a 2-flop synchronizer; logic uses synced values.
//  - Decode on seg[6:0]: 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8
//    10->9; 7F (blank) -> 4'hF, legal. All other patterns are illegal.
//  - FSM states:
//    IDLE : an_n all 1s or not one-hot-low; counter=0. Legal one-hot -> TRACK.
//    TRACK: counter increments while {an_n,seg} equals previous synced sample;
//           on any change counter reloads to 1 (stay TRACK), or goes IDLE if
//           an_n is no longer legal. counter==STABLE_CNT -> commit, go HELD.
//    HELD : no further commits; on any change in {an_n,seg} -> TRACK (count=1)
//           or IDLE.
//  - Commit (legal pattern): write digit_out[i], dp_out[i], set digit_valid[i];
//    upd_stb=1 next cycle only if value or dp differs, or digit_valid[i] was 0.
//  - Commit (illegal pattern): digit_out[i] unchanged, digit_valid[i]=0,
//    err_idx=i, err_stb=1 next cycle; upd_stb not asserted.
//  - Latency: pins stable from edge t -> upd_stb/err_stb high in cycle
//    t+STABLE_CNT+2, exactly 1 cycle wide; one commit per dwell.
//  - Multiple anodes low (ghosting): no commit, no error, FSM to IDLE.
//  - Mid-operation reset: all outputs return to reset values asynchronously;
//    in-progress qualification is discarded.
//  - Counter width $clog2(STABLE_CNT+1); saturates in HELD, never wraps.
// CONFIGURATION
//  SEG_HEX_DECODE_EN defined: additionally decode 08->A 03->b 46->C 21->d 06->E
//    0E->F as legal; committing hex F sets digit_valid (distinct from blank only
//    via digit_valid history - blank also yields 4'hF).
//  Not defined: those six patterns are illegal (err_stb path).
// TESTING
//  1. Reset: rst_n=0 mid-run -> digit_out=16'hFFFF, digit_valid=0, no strobes.
//  2. an_n=4'b1110, seg=8'hA4 held 10 cycles -> digit_out[3:0]=2, valid[0]=1,
//     single upd_stb in cycle t+5 (STABLE_CNT=3), no second pulse.
//  3. Scan 1,2,3,4 across positions (8'hF9,8'hA4,8'hB0,8'h99; 8 cycles each)
//     -> digit_out=16'h4321, 4 upd_stb pulses; second identical scan -> none.
//  4. an_n=4'b1101, seg=8'h7F->8'h88 -> without SEG_HEX_DECODE_EN: err_stb,
//     err_idx=1, valid[1]=0; with macro: digit_out[7:4]=A, upd_stb.
//  5. Glitch: seg toggles every 2 cycles (STABLE_CNT=3) -> no commits;
//     an_n=4'b0011 for 10 cycles -> no commit, no err_stb.
//  6. seg=8'h40 (dp lit, '0') on pos 3 -> dp_out[3]=1, digit_out[15:12]=0.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Purpose: decodes a sampled, multiplexed, active-low 7-segment bus back to per-position digit values.
// Latency: pins stable from edge t -> upd_stb/err_stb high in cycle t+STABLE_CNT+2, one cycle wide.
// Backpressure: none; a passive observer that never stalls the bus it samples. Build option: SEG_HEX_DECODE_EN.
module seg_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                seg_pins,
    input  logic [NUM_DIGITS-1:0]     an_n,
    output logic [4*NUM_DIGITS-1:0]   digit_out,
    output logic [NUM_DIGITS-1:0]     dp_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      upd_stb,
    output logic                      err_stb,
    output logic [2:0]                err_idx
);

    localparam int CW = (STABLE_CNT < 1) ? 1 : $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic [7:0]            seg_s1, seg_s2, prev_seg;
    logic [NUM_DIGITS-1:0] an_s1, an_s2, prev_an;

    logic       sample_chg;
    logic       sample_legal;
    logic       commit;
    logic [4:0] dec;
    logic       dp_new;
    logic [2:0] pos_idx;
    logic [3:0] cur_digit;
    logic       cur_dp;
    logic       cur_valid;
    logic       shows_change;

    // Exactly one anode driven low; zero or several low is idle or ghosting.
    function automatic logic onehot_low(input logic [NUM_DIGITS-1:0] a);
        int n;
        n = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!a[i]) n = n + 1;
        end
        return (n == 1);
    endfunction

    // Returns {legal, value}; blank is legal and reads back as 4'hF.
    function automatic logic [4:0] decode7(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h7F:   r = 5'h1F;
`ifdef SEG_HEX_DECODE_EN
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
`endif
            default: r = 5'h0F;
        endcase
        return r;
    endfunction

    // Two-flop synchronizer plus a copy of the previous synced sample for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= '1;
            seg_s2   <= '1;
            an_s1    <= '1;
            an_s2    <= '1;
            prev_seg <= '1;
            prev_an  <= '1;
        end else begin
            seg_s1   <= seg_pins;
            seg_s2   <= seg_s1;
            an_s1    <= an_n;
            an_s2    <= an_s1;
            prev_seg <= seg_s2;
            prev_an  <= an_s2;
        end
    end

    assign sample_chg   = ({an_s2, seg_s2} != {prev_an, prev_seg});
    assign sample_legal = onehot_low(an_s2);

    // The committed pattern is the one held in prev_* (the value that stayed stable).
    assign dec    = decode7(prev_seg[6:0]);
    assign dp_new = ~prev_seg[7];

    // Locate the active position and fetch what is currently stored there.
    always_comb begin
        pos_idx   = '0;
        cur_digit = 4'hF;
        cur_dp    = 1'b0;
        cur_valid = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!prev_an[i]) begin
                pos_idx   = 3'(i);
                cur_digit = digit_out[4*i +: 4];
                cur_dp    = dp_out[i];
                cur_valid = digit_valid[i];
            end
        end
    end

    assign shows_change = !cur_valid || (cur_digit != dec[3:0]) || (cur_dp != dp_new);

    // State and dwell-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Qualification FSM: count identical samples, commit once per dwell.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (sample_legal) begin
                    state_nx = TRACK;
                    cnt_nx   = CNT_ONE;
                end
            end
            TRACK: begin
                if (cnt == CNT_MAX) begin
                    commit = 1'b1;
                    if (!sample_chg) begin
                        state_nx = HELD;
                    end else if (sample_legal) begin
                        cnt_nx = CNT_ONE;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else if (sample_chg) begin
                    if (sample_legal) begin
                        cnt_nx = CNT_ONE;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (sample_chg) begin
                    if (sample_legal) begin
                        state_nx = TRACK;
                        cnt_nx   = CNT_ONE;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Commit into the per-position store and raise the matching strobe for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_out   <= '1;
            dp_out      <= '0;
            digit_valid <= '0;
            upd_stb     <= 1'b0;
            err_stb     <= 1'b0;
            err_idx     <= '0;
        end else begin
            upd_stb <= 1'b0;
            err_stb <= 1'b0;
            if (commit) begin
                if (dec[4]) begin
                    upd_stb <= shows_change;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (!prev_an[i]) begin
                            digit_out[4*i +: 4] <= dec[3:0];
                            dp_out[i]           <= dp_new;
                            digit_valid[i]      <= 1'b1;
                        end
                    end
                end else begin
                    err_stb <= 1'b1;
                    err_idx <= pos_idx;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (!prev_an[i]) digit_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
